// File: rtl/lsu_wb_master_if.sv
// Load/store request and single-word memory bus signals for lsu_wb_master.
// master: the LSU side; slave: the core plus bus responder environment.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface lsu_wb_master_if;
    logic                  Lsu_req;
    logic                  Lsu_we;
    logic [2:0]            Lsu_funct3;
    logic [`ADDR_SIZE-1:0] Lsu_addr;
    logic [`WORD_SIZE-1:0] Lsu_wdata;
    logic                  Lsu_busy;
    logic                  Lsu_done;
    logic [`WORD_SIZE-1:0] Lsu_rdata;
    logic                  Lsu_err;
    logic [`ADDR_SIZE-1:0] Wb_addr;
    logic                  Wb_cs;
    logic                  Wb_we;
    logic [`WORD_SIZE-1:0] Wb_wdata;
    logic [`WORD_SIZE-1:0] Wb_rdata;
    logic                  Wb_ack;

    modport master (
        input  Lsu_req, Lsu_we, Lsu_funct3, Lsu_addr, Lsu_wdata, Wb_rdata, Wb_ack,
        output Lsu_busy, Lsu_done, Lsu_rdata, Lsu_err, Wb_addr, Wb_cs, Wb_we, Wb_wdata
    );

    modport slave (
        output Lsu_req, Lsu_we, Lsu_funct3, Lsu_addr, Lsu_wdata, Wb_rdata, Wb_ack,
        input  Lsu_busy, Lsu_done, Lsu_rdata, Lsu_err, Wb_addr, Wb_cs, Wb_we, Wb_wdata
    );
endinterface

// File: rtl/lsu_wb_master.sv
// LSU bus initiator: word reads with B/H extraction, read-modify-write for B/H stores.
// Define LSU_MISALIGN_TRAP_EN to fail misaligned H/W accesses without touching the bus.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic             Clk,
    input logic             Rst,
    lsu_wb_master_if.master bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e                state_q, state_d;
    logic [`ADDR_SIZE-1:0] addr_q, addr_d;
    logic [`WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [15:0]           store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic [`WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic illegal;
    logic misalign;
    logic timeout_hit;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign illegal = (bus.Lsu_funct3 == 3'b011) || (bus.Lsu_funct3 == 3'b110) ||
                     (bus.Lsu_funct3 == 3'b111) || (bus.Lsu_we && bus.Lsu_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((bus.Lsu_funct3[1:0] == 2'b01) && bus.Lsu_addr[0]) ||
                      ((bus.Lsu_funct3[1:0] == 2'b10) && (bus.Lsu_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Ack takes priority over the timeout in the cycle the counter tops out.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Lsu_req) begin
                    addr_d   = bus.Lsu_addr;
                    funct3_d = bus.Lsu_funct3;
                    we_d     = bus.Lsu_we;
                    store_d  = bus.Lsu_wdata[15:0];
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    if (illegal || misalign) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (bus.Lsu_we && (bus.Lsu_funct3 == 3'b010)) begin
                        wdata_d = bus.Lsu_wdata;
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (bus.Wb_ack) begin
                    cnt_d = '0;
                    if (we_q) begin
                        wdata_d = funct3_q[0] ? {bus.Wb_rdata[31:16], store_q[15:0]}
                                              : {bus.Wb_rdata[31:8], store_q[7:0]};
                        state_d = StWr;
                    end else begin
                        rdata_d = load_ext(funct3_q, bus.Wb_rdata);
                        state_d = StDone;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWr: begin
                if (bus.Wb_ack) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Lsu_busy  = (state_q != StIdle);
    assign bus.Lsu_done  = (state_q == StDone);
    assign bus.Lsu_rdata = rdata_q;
    assign bus.Lsu_err   = err_q;
    assign bus.Wb_addr   = addr_q;
    assign bus.Wb_cs     = (state_q == StRd) || (state_q == StWr);
    assign bus.Wb_we     = (state_q == StWr);
    assign bus.Wb_wdata  = wdata_q;

endmodule
